// File: rtl/hdc_class_search.sv
// Sequential associative-memory search: scans N_CLASS binarised class hypervectors,
// one per cycle, and reports the class with the largest overlap with the query.
module hdc_class_search #(
  parameter int HV_W      = 50,
  parameter int N_CLASS   = 26,
  parameter int CLS_W     = 5,
  parameter int SCORE_W   = 6,
  parameter int MIN_SCORE = 1
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    query_valid,
  output logic                    query_ready,
  input  logic [HV_W-1:0]         query_hv,
  input  logic [N_CLASS*HV_W-1:0] class_hvs,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [CLS_W-1:0]        result_class,
  output logic [SCORE_W-1:0]      result_score,
  output logic                    result_hit,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e             state_q, state_d;
  logic [HV_W-1:0]    q_reg_q, q_reg_d;
  logic [CLS_W-1:0]   idx_q, idx_d;
  logic [SCORE_W-1:0] best_score_q, best_score_d;
  logic [CLS_W-1:0]   best_class_q, best_class_d;

  logic [HV_W-1:0]    cur_class;
  logic [SCORE_W-1:0] score;

  function automatic logic [SCORE_W-1:0] popcount(input logic [HV_W-1:0] v);
    logic [SCORE_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < HV_W; i++) begin
      cnt = cnt + SCORE_W'(v[i]);
    end
    return cnt;
  endfunction

  // Class vectors are read live; upstream holds them stable while busy.
  always_comb begin
    cur_class = class_hvs[int'(idx_q)*HV_W +: HV_W];
    score     = popcount(q_reg_q & cur_class);
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    q_reg_d      = q_reg_q;
    idx_d        = idx_q;
    best_score_d = best_score_q;
    best_class_d = best_class_q;
    unique case (state_q)
      IDLE: begin
        if (query_valid) begin
          q_reg_d      = query_hv;
          idx_d        = '0;
          best_score_d = '0;
          best_class_d = '0;
          state_d      = SCAN;
        end
      end
      SCAN: begin
        // Strictly-greater update keeps the lowest index on ties.
        if (score > best_score_q) begin
          best_score_d = score;
          best_class_d = idx_q;
        end
        if (idx_q == CLS_W'(N_CLASS-1)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + CLS_W'(1);
        end
      end
      DONE: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      q_reg_q      <= '0;
      idx_q        <= '0;
      best_score_q <= '0;
      best_class_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      q_reg_q      <= q_reg_d;
      idx_q        <= idx_d;
      best_score_q <= best_score_d;
      best_class_q <= best_class_d;
    end
  end

  assign query_ready  = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result_class = best_class_q;
  assign result_score = best_score_q;
  assign result_hit   = (best_score_q >= SCORE_W'(MIN_SCORE));

endmodule

// File: tb/tb_hdc_class_search.sv
// Directed bench for hdc_class_search: expected results are queued at query
// acceptance and compared when result_valid is observed.
module tb_hdc_class_search;

  localparam int HV_W    = 50;
  localparam int N_CLASS = 26;
  localparam int CLS_W   = 5;
  localparam int SCORE_W = 6;

  typedef struct {
    logic [CLS_W-1:0]   cls;
    logic [SCORE_W-1:0] score;
    logic               hit;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    nrst;
  logic                    query_valid;
  logic                    query_ready;
  logic [HV_W-1:0]         query_hv;
  logic [N_CLASS*HV_W-1:0] class_hvs;
  logic                    result_valid;
  logic                    result_ready;
  logic [CLS_W-1:0]        result_class;
  logic [SCORE_W-1:0]      result_score;
  logic                    result_hit;
  logic                    busy;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  hdc_class_search dut (
    .clk          (clk),
    .nrst         (nrst),
    .query_valid  (query_valid),
    .query_ready  (query_ready),
    .query_hv     (query_hv),
    .class_hvs    (class_hvs),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_class (result_class),
    .result_score (result_score),
    .result_hit   (result_hit),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_class(input int i, input logic [HV_W-1:0] v);
    class_hvs[i*HV_W +: HV_W] = v;
  endtask

  task automatic accept(input logic [HV_W-1:0] q, input exp_t e, input bit hold);
    int n;
    n = 0;
    query_hv    = q;
    query_valid = 1'b1;
    while (!query_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("accept_timeout", 64'(n < 100), 64'd1);
    @(posedge clk); #1;
    exp_q.push_back(e);
    if (!hold) query_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int   lat;
    exp_t e;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1; lat++;
      if (result_valid) break;
    end
    check({tag, "_latency"}, 64'(lat), 64'd26);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_class"}, 64'(result_class), 64'(e.cls));
      check({tag, "_score"}, 64'(result_score), 64'(e.score));
      check({tag, "_hit"},   64'(result_hit),   64'(e.hit));
    end else begin
      check({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
    end
  endtask

  task automatic release_result(input string tag);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(result_valid), 64'd0);
    check({tag, "_ready_idle"}, 64'(query_ready), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_query_ready"},  64'(query_ready),  64'd1);
    check({tag, "_busy"},         64'(busy),         64'd0);
    check({tag, "_result_valid"}, 64'(result_valid), 64'd0);
    check({tag, "_outputs"}, 64'({result_class, result_score, result_hit}), 64'd0);
  endtask

  initial begin
    logic [HV_W-1:0] ones;
    logic [SCORE_W+CLS_W:0] held;
    bit saw_valid;

    ones         = '1;
    nrst         = 1'b0;
    query_valid  = 1'b0;
    query_hv     = '0;
    class_hvs    = '0;
    result_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    nrst = 1'b1;
    @(negedge clk);

    // Basic match.
    class_hvs = '0;
    set_class(3, 50'hFF);
    accept(50'hFF, '{cls: 5'd3, score: 6'd8, hit: 1'b1}, 1'b0);
    check("basic_scan_busy", 64'(busy), 64'd1);
    check("basic_scan_not_ready", 64'(query_ready), 64'd0);
    wait_result("basic");
    release_result("basic");

    // Tie-break keeps lower index.
    class_hvs = '0;
    set_class(5, 50'h0F);
    set_class(9, 50'hF0);
    accept(50'hFF, '{cls: 5'd5, score: 6'd4, hit: 1'b1}, 1'b0);
    wait_result("tie");
    release_result("tie");

    // No match.
    class_hvs = '0;
    accept(50'h3FFFF_FFFFFFFF, '{cls: 5'd0, score: 6'd0, hit: 1'b0}, 1'b0);
    wait_result("nomatch");
    release_result("nomatch");

    // Full overlap on the last class.
    class_hvs = '0;
    set_class(25, ones);
    set_class(0, 50'h1);
    accept(ones, '{cls: 5'd25, score: 6'd50, hit: 1'b1}, 1'b0);
    wait_result("full");
    release_result("full");

    // Back-pressure with query_valid held and a different second query.
    class_hvs = '0;
    set_class(3, 50'hFF);
    set_class(7, 50'hFF00);
    accept(50'hFF, '{cls: 5'd3, score: 6'd8, hit: 1'b1}, 1'b1);
    query_hv = 50'hFF00;
    check("bp_scan_not_ready", 64'(query_ready), 64'd0);
    wait_result("bp_first");
    held = {result_class, result_score, result_hit};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 64'(result_valid), 64'd1);
      check("bp_hold_stable", 64'({result_class, result_score, result_hit}), 64'(held));
      check("bp_hold_not_ready", 64'(query_ready), 64'd0);
    end
    release_result("bp_first");
    @(posedge clk); #1;
    exp_q.push_back('{cls: 5'd7, score: 6'd8, hit: 1'b1});
    check("bp_second_accepted", 64'(busy), 64'd1);
    query_valid = 1'b0;
    wait_result("bp_second");
    release_result("bp_second");

    // Reset mid-scan at index 12.
    class_hvs = '0;
    set_class(3, 50'hFF);
    accept(50'hFF, '{cls: 5'd3, score: 6'd8, hit: 1'b1}, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    check("midreset_busy_before", 64'(busy), 64'd1);
    nrst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (result_valid) saw_valid = 1'b1;
    end
    check("midreset_no_result", 64'(saw_valid), 64'd0);

    // Fresh query after reset release.
    class_hvs = '0;
    set_class(25, ones);
    set_class(0, 50'h1);
    accept(ones, '{cls: 5'd25, score: 6'd50, hit: 1'b1}, 1'b0);
    wait_result("post_reset");
    release_result("post_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
